// File: rtl/asic_ram_readout_mc.sv
// Multi-lane serial ASIC readout: per-lane deserialisers feed a round-robin
// arbiter that writes assembled words into an external FIFO.
module asic_ram_readout_mc #(
  parameter int NUM_CH      = 4,
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 3,
  parameter bit INVERT_DATA = 1'b1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ReadClk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] AsicDin,
  input  logic [NUM_CH-1:0] TransmitOn,
  input  logic [NUM_CH-1:0] ChEnable,
  input  logic              ExternalFifoFull,
  input  logic              ClearStatus,
  output logic [WORD_W-1:0] ExternalFifoData,
  output logic [CH_W-1:0]   ExternalFifoChan,
  output logic              ExternalFifoWriteEn,
  output logic              ReadDone,
  output logic              Overflow,
  output logic              PartialWord
);

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [WORD_W-1:0] MSB_ONE  = {1'b1, {(WORD_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} laneState_t;

  logic [NUM_CH-1:0] dinSync [SYNC_STAGES];
  logic [NUM_CH-1:0] txSync  [SYNC_STAGES];
  logic [NUM_CH-1:0] dinDly;
  logic [NUM_CH-1:0] txDly;

  laneState_t        laneState [NUM_CH];
  logic [CNT_W-1:0]  bitCount  [NUM_CH];
  logic [WORD_W-1:0] shiftReg  [NUM_CH];
  logic [WORD_W-1:0] holdReg   [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] doneFlag;
  logic [CH_W-1:0]   rrPtr;

  logic [WORD_W-1:0] shiftNext [NUM_CH];
  logic [WORD_W-1:0] eventWord [NUM_CH];
  logic [NUM_CH-1:0] wordEvent;
  logic [NUM_CH-1:0] laneBusy;
  logic [NUM_CH-1:0] grantHit;
  logic              flushEvent;
  logic              grantValid;
  logic [CH_W-1:0]   grantIdx;
  logic [CH_W-1:0]   candIdx;
  int                cand;
  logic              allDone;
  logic              overflowEvent;

  // Negedge synchroniser; the extra data stage lines the first bit up with
  // the first READ cycle, and TransmitOn is delayed alongside it.
  always_ff @(negedge ReadClk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        dinSync[s] <= '0;
        txSync[s]  <= '1;
      end
      dinDly <= '0;
      txDly  <= '1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, which is what makes this a shift chain.
      dinSync[0] <= AsicDin;
      txSync[0]  <= TransmitOn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        dinSync[s] <= dinSync[s-1];
        txSync[s]  <= txSync[s-1];
      end
      dinDly <= dinSync[SYNC_STAGES-1];
      txDly  <= txSync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    wordEvent  = '0;
    laneBusy   = '0;
    flushEvent = 1'b0;
    for (int l = 0; l < NUM_CH; l++) begin
      shiftNext[l] = shiftReg[l] |
                     ({WORD_W{dinDly[l] ^ INVERT_DATA}} & (MSB_ONE >> bitCount[l]));
      eventWord[l] = (laneState[l] == FLUSH) ? shiftReg[l] : shiftNext[l];
      wordEvent[l] = (laneState[l] == FLUSH) ||
                     ((laneState[l] == READ) && !txDly[l] && (bitCount[l] == LAST_BIT));
      laneBusy[l]  = (laneState[l] != IDLE);
      if (laneState[l] == FLUSH) flushEvent = 1'b1;
    end
  end

  // Round-robin search begins at rrPtr, the lane after the last one granted.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    candIdx    = '0;
    grantHit   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      candIdx = CH_W'(cand);
      if (!ExternalFifoFull && !grantValid && pending[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
    for (int l = 0; l < NUM_CH; l++) begin
      grantHit[l] = grantValid && (grantIdx == CH_W'(l));
    end
  end

  // A lane still mid-frame stays required even if its mask bit drops.
  assign allDone       = (|doneFlag) && (&(doneFlag | ~(ChEnable | laneBusy)));
  assign overflowEvent = |(wordEvent & pending & ~grantHit);

  always_ff @(posedge ReadClk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the holding registers are reset too, so a word caught by reset
      // can never surface as stale data afterwards.
      for (int l = 0; l < NUM_CH; l++) begin
        laneState[l] <= IDLE;
        bitCount[l]  <= '0;
        shiftReg[l]  <= '0;
        holdReg[l]   <= '0;
      end
      pending             <= '0;
      doneFlag            <= '0;
      rrPtr               <= '0;
      ExternalFifoData    <= '0;
      ExternalFifoChan    <= '0;
      ExternalFifoWriteEn <= 1'b0;
      ReadDone            <= 1'b0;
      Overflow            <= 1'b0;
      PartialWord         <= 1'b0;
    end else begin
      ExternalFifoWriteEn <= grantValid;
      if (grantValid) begin
        ExternalFifoData <= holdReg[grantIdx];
        ExternalFifoChan <= grantIdx;
        rrPtr            <= (int'(grantIdx) == NUM_CH - 1) ? '0 : grantIdx + 1'b1;
      end

      ReadDone    <= allDone;
      Overflow    <= (Overflow & ~ClearStatus) | overflowEvent;
      PartialWord <= (PartialWord & ~ClearStatus) | flushEvent;
      if (allDone) doneFlag <= '0;

      for (int l = 0; l < NUM_CH; l++) begin
        // A granted lane may reload in the same cycle; otherwise a busy
        // holding register keeps its old word and the new one is dropped.
        if (wordEvent[l]) begin
          if (!pending[l] || grantHit[l]) begin
            holdReg[l] <= eventWord[l];
            pending[l] <= 1'b1;
          end
        end else if (grantHit[l]) begin
          pending[l] <= 1'b0;
        end

        case (laneState[l])
          IDLE: begin
            bitCount[l] <= '0;
            shiftReg[l] <= '0;
            if (!txSync[SYNC_STAGES-1][l] && ChEnable[l] && !doneFlag[l])
              laneState[l] <= READ;
          end
          READ: begin
            if (txDly[l]) begin
              laneState[l] <= (bitCount[l] == '0) ? DONE : FLUSH;
            end else if (bitCount[l] == LAST_BIT) begin
              bitCount[l] <= '0;
              shiftReg[l] <= '0;
            end else begin
              bitCount[l] <= bitCount[l] + 1'b1;
              shiftReg[l] <= shiftNext[l];
            end
          end
          FLUSH: begin
            bitCount[l]  <= '0;
            shiftReg[l]  <= '0;
            laneState[l] <= DONE;
          end
          DONE: begin
            doneFlag[l]  <= 1'b1;
            laneState[l] <= IDLE;
          end
          default: laneState[l] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_asic_ram_readout_mc.sv
// Scoreboard bench for asic_ram_readout_mc: expected FIFO writes are queued as
// frames are driven and popped as the DUT strobes ExternalFifoWriteEn.
module tb_asic_ram_readout_mc;

  localparam int NUM_CH = 4;
  localparam int WORD_W = 16;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [CH_W-1:0]   chan;
    logic [WORD_W-1:0] data;
  } wrExp_t;

  logic              ReadClk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] AsicDin;
  logic [NUM_CH-1:0] TransmitOn;
  logic [NUM_CH-1:0] ChEnable;
  logic              ExternalFifoFull;
  logic              ClearStatus;
  logic [WORD_W-1:0] ExternalFifoData;
  logic [CH_W-1:0]   ExternalFifoChan;
  logic              ExternalFifoWriteEn;
  logic              ReadDone;
  logic              Overflow;
  logic              PartialWord;

  wrExp_t      expQ[$];
  wrExp_t      monExp;
  int          testCount = 0;
  int          failCount = 0;
  int          doneCount = 0;
  logic [63:0] laneBits [NUM_CH];
  int          laneLen  [NUM_CH];
  logic        fullQ = 1'b0;

  asic_ram_readout_mc #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .SYNC_STAGES(3), .INVERT_DATA(1'b1)
  ) dut (
    .ReadClk(ReadClk),
    .reset_n(reset_n),
    .AsicDin(AsicDin),
    .TransmitOn(TransmitOn),
    .ChEnable(ChEnable),
    .ExternalFifoFull(ExternalFifoFull),
    .ClearStatus(ClearStatus),
    .ExternalFifoData(ExternalFifoData),
    .ExternalFifoChan(ExternalFifoChan),
    .ExternalFifoWriteEn(ExternalFifoWriteEn),
    .ReadDone(ReadDone),
    .Overflow(Overflow),
    .PartialWord(PartialWord)
  );

  always #5 ReadClk = ~ReadClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input int ch, input logic [WORD_W-1:0] d);
    wrExp_t e;
    e.chan = CH_W'(ch);
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic clearLanes();
    for (int l = 0; l < NUM_CH; l++) begin
      laneBits[l] = '0;
      laneLen[l]  = 0;
    end
  endtask

  // Serial bits go MSB first and complemented, so the stored word equals laneBits.
  task automatic driveCycle(input int c);
    logic [63:0] tmp;
    for (int l = 0; l < NUM_CH; l++) begin
      if (c < laneLen[l]) begin
        tmp           = laneBits[l] >> (laneLen[l] - 1 - c);
        TransmitOn[l] = 1'b0;
        AsicDin[l]    = ~tmp[0];
      end else begin
        TransmitOn[l] = 1'b1;
        AsicDin[l]    = 1'b0;
      end
    end
  endtask

  task automatic runFrame(input int cycles, input int fullStart, input int fullEnd);
    for (int c = 0; c < cycles; c++) begin
      @(posedge ReadClk); #1;
      driveCycle(c);
      ExternalFifoFull = (c >= fullStart) && (c < fullEnd);
    end
    @(posedge ReadClk); #1;
    driveCycle(cycles);
    ExternalFifoFull = 1'b0;
  endtask

  task automatic endScenario(input string tag, input int expDone);
    repeat (40) @(posedge ReadClk);
    @(negedge ReadClk);
    check({tag, "_drained"}, expQ.size(), 0);
    check({tag, "_readdone"}, doneCount, expDone);
  endtask

  task automatic pulseClear();
    @(posedge ReadClk); #1;
    ClearStatus = 1'b1;
    @(posedge ReadClk); #1;
    ClearStatus = 1'b0;
    @(negedge ReadClk);
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_data"}, ExternalFifoData, 0);
    check({tag, "_chan"}, ExternalFifoChan, 0);
    check({tag, "_we"}, ExternalFifoWriteEn, 0);
    check({tag, "_readdone"}, ReadDone, 0);
    check({tag, "_ovf"}, Overflow, 0);
    check({tag, "_partial"}, PartialWord, 0);
  endtask

  always @(posedge ReadClk) fullQ <= ExternalFifoFull;

  always @(negedge ReadClk) begin
    if (ReadDone === 1'b1) doneCount++;
    if (ExternalFifoWriteEn === 1'b1) begin
      check("write_while_full", fullQ, 0);
      if (expQ.size() == 0) begin
        check("spurious_write", ExternalFifoWriteEn, 0);
      end else begin
        monExp = expQ.pop_front();
        check("wr_chan", ExternalFifoChan, monExp.chan);
        check("wr_data", ExternalFifoData, monExp.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [WORD_W-1:0] w;
    reset_n = 1'b0; AsicDin = '0; TransmitOn = '1; ChEnable = '0;
    ExternalFifoFull = 1'b0; ClearStatus = 1'b0;
    clearLanes();
    #1;
    checkOutputsZero("reset");
    repeat (3) @(posedge ReadClk); #1;
    reset_n = 1'b1;

    // Four lanes, two words each, all completing together: order 0,1,2,3 twice.
    doneCount = 0;
    ChEnable = 4'b1111;
    for (int n = 0; n < NUM_CH; n++) begin
      w = WORD_W'(16'h1111 * (n + 1));
      laneBits[n] = {32'h0, w, w};
      laneLen[n]  = 32;
    end
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < NUM_CH; n++) pushExp(n, WORD_W'(16'h1111 * (n + 1)));
    runFrame(32, -1, -1);
    endScenario("multi", 1);

    // Single 16-bit frame on lane 0.
    doneCount = 0; clearLanes();
    ChEnable = 4'b0001;
    laneBits[0] = 64'hA5C3; laneLen[0] = 16;
    pushExp(0, 16'hA5C3);
    runFrame(16, -1, -1);
    endScenario("single", 1);
    check("single_ovf", Overflow, 0);
    check("single_partial", PartialWord, 0);

    // 20-bit frame on lane 2: a full word, then the top nibble zero-padded.
    doneCount = 0; clearLanes();
    ChEnable = 4'b0100;
    laneBits[2] = 64'h3C5A7; laneLen[2] = 20;
    pushExp(2, 16'h3C5A);
    pushExp(2, 16'h7000);
    runFrame(20, -1, -1);
    endScenario("partial", 1);
    check("partial_flag", PartialWord, 1);
    check("partial_ovf", Overflow, 0);
    pulseClear();
    check("partial_cleared", PartialWord, 0);

    // FIFO full for 40 cycles across a 48-bit frame: only the first word survives.
    doneCount = 0; clearLanes();
    ChEnable = 4'b0001;
    laneBits[0] = 64'h1234_5678_9ABC; laneLen[0] = 48;
    pushExp(0, 16'h1234);
    runFrame(52, 12, 52);
    endScenario("full", 1);
    check("full_ovf", Overflow, 1);
    check("full_partial", PartialWord, 0);
    pulseClear();
    check("full_ovf_cleared", Overflow, 0);

    // Masked lanes 1/3 toggle but are ignored; the pointer sits at lane 1,
    // so lane 2 wins the tie before lane 0.
    doneCount = 0; clearLanes();
    ChEnable = 4'b0101;
    laneBits[0] = 64'hBEEF; laneLen[0] = 16;
    laneBits[1] = 64'h1357; laneLen[1] = 16;
    laneBits[2] = 64'h0F0F; laneLen[2] = 16;
    laneBits[3] = 64'h24_6813; laneLen[3] = 24;
    pushExp(2, 16'h0F0F);
    pushExp(0, 16'hBEEF);
    runFrame(24, -1, -1);
    endScenario("masked", 1);

    // Reset at bit 9 of a frame: outputs clear at once, nothing is written.
    doneCount = 0; clearLanes();
    ChEnable = 4'b0001;
    laneBits[0] = 64'h6D2B; laneLen[0] = 16;
    for (int c = 0; c < 9; c++) begin
      @(posedge ReadClk); #1;
      driveCycle(c);
    end
    @(posedge ReadClk); #1;
    reset_n = 1'b0; TransmitOn = '1; AsicDin = '0;
    #1;
    checkOutputsZero("midreset");
    repeat (3) @(posedge ReadClk); #1;
    reset_n = 1'b1;
    endScenario("rst_abort", 0);

    doneCount = 0;
    pushExp(0, 16'h6D2B);
    runFrame(16, -1, -1);
    endScenario("rst_recover", 1);
    check("rst_recover_ovf", Overflow, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/asic_ram_readout_mc.md
ASIC_RAM_READOUT_MC -- requirements
Module: asic_ram_readout_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of parallel serial ASIC lanes, legal range 1..8.
REQ-002 Parameter WORD_W, default 16: bits per output word, legal range 8..32; WORD_W >= NUM_CH.
REQ-003 Parameter SYNC_STAGES, default 3: negedge synchroniser depth on AsicDin/TransmitOn, legal range 2..4.
REQ-004 Parameter INVERT_DATA, default 1: 1 = store complemented serial bit, 0 = store true bit.
REQ-005 ReadClk  input  1  readout clock; all state on posedge, synchroniser on negedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 AsicDin  input  NUM_CH  serial data, one bit per lane, MSB first.
REQ-008 TransmitOn  input  NUM_CH  per-lane frame enable, active-low (low = ASIC transmitting).
REQ-009 ChEnable  input  NUM_CH  lane mask; disabled lanes never leave IDLE and count as done.
REQ-010 ExternalFifoFull  input  1  downstream FIFO full; no write issued while high.
REQ-011 ClearStatus  input  1  one-cycle pulse, clears Overflow and PartialWord.
REQ-012 ExternalFifoData  output  WORD_W  assembled word.
REQ-013 ExternalFifoChan  output  clog2(NUM_CH), min 1  lane index of current word.
REQ-014 ExternalFifoWriteEn  output  1  one-cycle write strobe, qualifies Data/Chan.
REQ-015 ReadDone  output  1  one-cycle pulse when every enabled lane has finished its frame.
REQ-016 Overflow  output  1  sticky: a completed word was dropped.
REQ-017 PartialWord  output  1  sticky: a frame ended with an incomplete word.

Function
REQ-018 AsicDin and TransmitOn SHALL pass SYNC_STAGES negedge flops; data path SHALL have one further negedge stage so the first sampled bit aligns with the first READ cycle.
REQ-019 Each lane SHALL run FSM IDLE -> READ -> (FLUSH) -> DONE -> IDLE.
REQ-020 IDLE: bit counter and shift register cleared; enter READ on the cycle after synchronised TransmitOn low and ChEnable set.
REQ-021 READ: each cycle shift in one bit (INVERT_DATA applied) at position WORD_W-1-count; count increments, wraps WORD_W-1 -> 0.
REQ-022 Word complete (count = WORD_W-1 while shifting): word copied to lane holding register, lane pending flag set, next cycle continues with count 0 (no gap bit).
REQ-023 READ exits when delayed synchronised TransmitOn high: count = 0 -> DONE; count != 0 -> FLUSH.
REQ-024 FLUSH (one cycle): unfilled LSBs zero, word moved to holding register as pending, PartialWord set; then DONE.
REQ-025 DONE (one cycle): lane done flag set, return to IDLE; new frame accepted only after ReadDone cleared flags.
REQ-026 ReadDone SHALL pulse one cycle after all enabled lanes' done flags are set, clearing all done flags same cycle; ChEnable = 0 gives no ReadDone.
REQ-027 Arbiter: round-robin over pending lanes starting after last granted lane; one grant per cycle when ExternalFifoFull low.
REQ-028 Grant: ExternalFifoData/Chan registered, ExternalFifoWriteEn high exactly one cycle (one-cycle latency from pending), pending cleared.
REQ-029 Lane completes a word while its pending flag set and not granted that cycle: new word dropped, old kept, Overflow set.
REQ-030 Grant and new completion on same lane same cycle: old word written, new word loaded, no Overflow.
REQ-031 ExternalFifoFull high: WriteEn held low, pending words retained, arbiter pointer frozen.
REQ-032 ClearStatus and a new Overflow/PartialWord event same cycle: flag set (event wins).
REQ-033 ChEnable deasserted mid-frame: lane continues current frame to DONE; mask sampled only in IDLE.

Reset
REQ-034 reset_n low SHALL asynchronously force all FSMs to IDLE, counters, shift/holding registers, pending and done flags to 0, arbiter pointer to lane 0.
REQ-035 Reset values: ExternalFifoData 0, ExternalFifoChan 0, ExternalFifoWriteEn 0, ReadDone 0, Overflow 0, PartialWord 0; synchroniser flops reset TransmitOn stages to 1, data stages to 0.
REQ-036 Reset mid-frame SHALL discard partial words with no write and no ReadDone after release.

Verification
REQ-037 NUM_CH=1, WORD_W=16, INVERT=1, frame of 16 bits encoding ~0xA5C3 -> one write 0xA5C3, Chan 0, then ReadDone one pulse, flags 0.
REQ-038 NUM_CH=4, all lanes 32-bit frames simultaneously, lane n sends words 0x1111*(n+1) -> 8 writes, order Chan 0,1,2,3,0,1,2,3, ReadDone once after last.
REQ-039 20-bit frame on lane 2, WORD_W=16 -> writes word0 then top 4 bits with 12 zero LSBs, PartialWord=1; ClearStatus -> 0.
REQ-040 ExternalFifoFull held high 40 cycles during 48-bit frame on lane 0 -> first word kept, later words dropped, Overflow=1; after release exactly one write.
REQ-041 ChEnable=4'b0101, lanes 0 and 2 framed -> ReadDone after both, lanes 1/3 TransmitOn activity ignored, no writes from Chan 1/3.
REQ-042 reset_n pulsed low at bit 9 of a 16-bit frame -> all outputs 0 immediately, no write; next full frame captured correctly.
